// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcode values, instruction type encoding and field positions.
package mips_pkg;

    localparam int unsigned InstrW = 32;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef enum logic [1:0] {
        TypeR = 2'd0,
        TypeI = 2'd1,
        TypeJ = 2'd2
    } instr_type_e;

    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RsLsb     = 21;
    localparam int unsigned RtLsb     = 16;
    localparam int unsigned RdLsb     = 11;
    localparam int unsigned ShamtLsb  = 6;
    localparam int unsigned FunctLsb  = 0;
    localparam int unsigned ImmLsb    = 0;
    localparam int unsigned TargetLsb = 0;

    function automatic logic opcode_legal(input logic [5:0] op);
        return op inside {OpRtype, OpJ, OpJal, OpBeq, OpBne, OpAddi, OpAndi, OpOri, OpLw, OpSw};
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction and type classification of one 32-bit MIPS instruction.
module instr_field_decode
    import mips_pkg::*;
(
    input  logic [InstrW-1:0] instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [31:0]       imm,
    output logic [25:0]       target,
    output logic [1:0]        instr_type
);

    instr_type_e type_enc;

    assign opcode = instr[OpcodeLsb +: 6];
    assign rs     = instr[RsLsb +: 5];
    assign rt     = instr[RtLsb +: 5];
    assign rd     = instr[RdLsb +: 5];
    assign shamt  = instr[ShamtLsb +: 5];
    assign funct  = instr[FunctLsb +: 6];
    assign imm    = {{16{instr[ImmLsb + 15]}}, instr[ImmLsb +: 16]};
    assign target = instr[TargetLsb +: 26];

    always_comb begin
        type_enc = TypeI;
        if (opcode == OpRtype) begin
            type_enc = TypeR;
        end else if (opcode == OpJ || opcode == OpJal) begin
            type_enc = TypeJ;
        end
    end

    assign instr_type = type_enc;

endmodule

// File: rtl/instr_decode_buffer.sv
// Two-entry instruction buffer between fetch and decode, presenting decoded head fields.
// Optional illegal-opcode flagging is enabled with the ILLEGAL_OPCODE_CHECK_EN macro.
module instr_decode_buffer
    import mips_pkg::*;
#(
    parameter int unsigned PC_W   = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [31:0]       out_imm,
    output logic [25:0]       out_target,
    output logic [1:0]        out_type,
    output logic              out_illegal,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] instr_mem [2];
    logic [PC_W-1:0]   pc_mem    [2];

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign count     = count_q;

    // Flush wins over both transfers so no stale entry survives it.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

    assign out_pc = pc_mem[rd_ptr_q];

    instr_field_decode u_field_decode (
        .instr      (instr_mem[rd_ptr_q]),
        .opcode     (out_opcode),
        .rs         (out_rs),
        .rt         (out_rt),
        .rd         (out_rd),
        .shamt      (out_shamt),
        .funct      (out_funct),
        .imm        (out_imm),
        .target     (out_target),
        .instr_type (out_type)
    );

`ifdef ILLEGAL_OPCODE_CHECK_EN
    assign out_illegal = out_valid && !opcode_legal(out_opcode);
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Directed bench: queue-based reference model checked every cycle plus literal spot checks.
module tb_instr_decode_buffer;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, out_imm;
    logic [4:0]  in_pc, out_pc, out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]  out_opcode, out_funct;
    logic [25:0] out_target;
    logic [1:0]  out_type, count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  pc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    instr_decode_buffer #(.PC_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_rd      (out_rd),
        .out_shamt   (out_shamt),
        .out_funct   (out_funct),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_type    (out_type),
        .out_illegal (out_illegal),
        .count       (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_field(input logic [31:0] w, input int lsb, input int width);
        return int'((longint'(w) / (64'd1 << lsb)) % (64'd1 << width));
    endfunction

    function automatic logic m_illegal(input int op);
`ifdef ILLEGAL_OPCODE_CHECK_EN
        return !(op == 0 || op == 2 || op == 3 || op == 4 || op == 5 || op == 8 ||
                 op == 12 || op == 13 || op == 35 || op == 43);
`else
        return (op < 0);
`endif
    endfunction

    // Per-cycle comparison of the DUT against the reference queue.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", count, q.size());
            chk("in_ready", in_ready, q.size() != 2);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() > 0) begin
                automatic logic [31:0] w = q[0].instr;
                automatic int op = m_field(w, 26, 6);
                automatic int lo = m_field(w, 0, 16);
                automatic longint imm = (lo >= 32768) ? longint'(lo) + 64'hFFFF0000 : longint'(lo);
                automatic int ty = (op == 0) ? 0 : ((op == 2 || op == 3) ? 2 : 1);
                chk("pc", out_pc, q[0].pc);
                chk("opcode", out_opcode, op);
                chk("rs", out_rs, m_field(w, 21, 5));
                chk("rt", out_rt, m_field(w, 16, 5));
                chk("rd", out_rd, m_field(w, 11, 5));
                chk("shamt", out_shamt, m_field(w, 6, 5));
                chk("funct", out_funct, m_field(w, 0, 6));
                chk("imm", out_imm, imm);
                chk("target", out_target, m_field(w, 0, 26));
                chk("type", out_type, ty);
                chk("illegal", out_illegal, m_illegal(op));
            end else begin
                chk("illegal_idle", out_illegal, 0);
            end
        end
    end

    // One clock: apply inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic v, input logic [31:0] ins, input logic [4:0] p,
                        input logic rdy, input logic fl, input logic rst);
        int pre;
        bit do_push, do_pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        pre     = q.size();
        do_push = v && (pre < 2) && !fl;
        do_pop  = rdy && (pre > 0);
        if (rst || fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{instr: ins, pc: p});
        end
        #1;
    endtask

    initial begin
        step(0, 32'h0, 5'd0, 0, 0, 1);
        step(0, 32'h0, 5'd0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal", out_illegal, 0);

        // First push: visible only after the edge.
        in_valid = 1'b1; in_instr = 32'h03020100; in_pc = 5'd0; out_ready = 1'b0;
        #1;
        chk("no_bypass", out_valid, 0);
        step(1, 32'h03020100, 5'd0, 0, 0, 0);
        chk("r_valid", out_valid, 1);
        chk("r_opcode", out_opcode, 0);
        chk("r_rs", out_rs, 24);
        chk("r_rt", out_rt, 2);
        chk("r_rd", out_rd, 0);
        chk("r_shamt", out_shamt, 4);
        chk("r_funct", out_funct, 0);
        chk("r_type", out_type, 0);
        chk("r_count", count, 1);

        // Fill, drop third push, then drain in order.
        step(1, 32'h20010005, 5'd4, 0, 0, 0);
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        step(1, 32'h20020006, 5'd8, 0, 0, 0);
        chk("drop_count", count, 2);
        chk("head_pc0", out_pc, 0);
        step(0, 32'h0, 5'd0, 1, 0, 0);
        chk("head_pc4", out_pc, 4);
        step(0, 32'h0, 5'd0, 1, 0, 0);
        chk("drained", count, 0);

        // Push at full with concurrent pop is rejected.
        step(1, 32'h20030001, 5'd8, 0, 0, 0);
        step(1, 32'h20040002, 5'd10, 0, 0, 0);
        step(1, 32'h20050003, 5'd12, 1, 0, 0);
        chk("full_pop_count", count, 1);
        chk("full_pop_pc", out_pc, 10);
        step(0, 32'h0, 5'd0, 1, 0, 0);
        step(0, 32'h0, 5'd0, 1, 0, 0);
        chk("empty_pop", count, 0);

        // Simultaneous push/pop at one entry.
        step(1, 32'h3C010001, 5'd12, 0, 0, 0);
        step(1, 32'h3C020002, 5'd16, 1, 0, 0);
        chk("pp_count", count, 1);
        chk("pp_pc", out_pc, 16);

        // Flush at full with a push pending.
        step(1, 32'h3C030003, 5'd20, 0, 0, 0);
        step(1, 32'h3C040004, 5'd24, 0, 1, 0);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);

        // Unsupported opcode 1.
        step(1, 32'h07060504, 5'd28, 0, 0, 0);
        chk("op1_opcode", out_opcode, 1);
        chk("op1_type", out_type, 1);
`ifdef ILLEGAL_OPCODE_CHECK_EN
        chk("op1_illegal", out_illegal, 1);
`else
        chk("op1_illegal", out_illegal, 0);
`endif
        step(0, 32'h0, 5'd0, 1, 0, 0);

        // Load word with negative offset.
        step(1, 32'h8C01FFFC, 5'd30, 0, 0, 0);
        chk("lw_opcode", out_opcode, 32'h23);
        chk("lw_rs", out_rs, 0);
        chk("lw_rt", out_rt, 1);
        chk("lw_imm", out_imm, 32'hFFFFFFFC);
        chk("lw_illegal", out_illegal, 0);

        // Jump-and-link behind it, held while stalled.
        step(1, 32'h0C000010, 5'd31, 0, 0, 0);
        step(0, 32'h0, 5'd0, 0, 0, 0);
        chk("stall_pc", out_pc, 30);
        step(0, 32'h0, 5'd0, 1, 0, 0);
        chk("jal_type", out_type, 2);
        chk("jal_target", out_target, 32'h10);

        // Reset mid-transfer beats push and pop.
        step(1, 32'h10220003, 5'd3, 0, 0, 0);
        step(1, 32'h14220004, 5'd5, 1, 0, 1);
        chk("midrst_count", count, 0);
        chk("midrst_ready", in_ready, 1);

        // Mixed traffic, checked only by the model.
        for (int i = 0; i < 24; i++) begin
            automatic logic [31:0] w = {6'(i * 7), 26'(i * 32'h01234567)};
            step(1'((i % 3) != 2), w, 5'(i), 1'((i % 4) < 2), 1'(i == 17), 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
